// File: rtl/sva_until_with_monitor.sv
// sva_until_with_monitor: runtime checker for $rose(valid) |-> valid [s_]until_with ready,
// emitting pass/fail pulses with saturating counters and obligation length.
module sva_until_with_monitor #(
  parameter bit STRONG = 1'b1,
  parameter int CNT_W  = 16,
  parameter int LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid,
  input  logic             ready,
  input  logic             flush,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [LEN_W-1:0] last_len,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic valid_q, pass_q, pass_d, fail_q, fail_d;
  logic [1:0] code_q, code_d;
  logic [LEN_W-1:0] len_q, len_d, last_q, last_d, cur_len;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, fcnt_q, fcnt_d;
  logic rose, active;
  assign rose    = valid & ~valid_q;
  assign active  = en & ((state_q == WAIT) | rose);
  // Length of the obligation including the current check cycle.
  assign cur_len = (state_q == IDLE) ? LEN_W'(1) : ((&len_q) ? len_q : len_q + 1'b1);
  always_comb begin
    state_d = IDLE;
    len_d   = len_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    code_d  = code_q;
    last_d  = last_q;
    if (active) begin
      if (!valid) begin
        fail_d = 1'b1;
        code_d = 2'b01;
      end else if (ready) begin
        pass_d = 1'b1;
      end else if (flush) begin
        fail_d = STRONG;
        pass_d = !STRONG;
        code_d = STRONG ? 2'b10 : code_q;
      end else begin
        state_d = WAIT;
        len_d   = cur_len;
      end
      last_d = (pass_d | fail_d) ? cur_len : last_q;
    end
    pcnt_d = (pass_d & ~&pcnt_q) ? pcnt_q + 1'b1 : pcnt_q;
    fcnt_d = (fail_d & ~&fcnt_q) ? fcnt_q + 1'b1 : fcnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      len_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= 2'b00;
      last_q  <= '0;
      pcnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid;
      len_q   <= len_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      code_q  <= code_d;
      last_q  <= last_d;
      pcnt_q  <= pcnt_d;
      fcnt_q  <= fcnt_d;
    end
  end
  assign busy      = (state_q == WAIT);
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_code = code_q;
  assign last_len  = last_q;
  assign pass_cnt  = pcnt_q;
  assign fail_cnt  = fcnt_q;
endmodule
